// File: rtl/ctrl_wei_seq.sv
// Weight-configuration sequencer: fetches a weight set from the distributor,
// then offers it to one PEC (sequential) or all enabled PECs (broadcast).
module ctrl_wei_seq #(
  parameter int NUM_PEC = 16,
  parameter int IDX_W   = $clog2(NUM_PEC),
  parameter int RND_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic               cfg_mode,
  input  logic [NUM_PEC-1:0] cfg_pec_mask,
  input  logic [RND_W-1:0]   cfg_num_round,
  output logic               fetch_req,
  input  logic               fetch_ack,
  output logic [NUM_PEC-1:0] pec_rdy_wei,
  input  logic [NUM_PEC-1:0] pec_get_wei,
  output logic [IDX_W-1:0]   cur_pec,
  output logic               busy,
  output logic               done,
  output logic               err_get,
  output logic [1:0]         dbg_state
);

  // Handshakes: fetch_req is a level held until the one-cycle fetch_ack;
  // pec_rdy_wei[i] is held until the one-cycle pec_get_wei[i], and a get
  // seen while rdy is low is a protocol error that is otherwise ignored.

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_OFFER, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [NUM_PEC-1:0] mask_q, mask_d;
  logic [RND_W-1:0]   nrnd_q, nrnd_d;
  logic [RND_W-1:0]   rnd_q, rnd_d;
  logic [IDX_W-1:0]   cur_q, cur_d;
  logic [NUM_PEC-1:0] rdy_q, rdy_d;
  logic               err_q, err_d;
  logic               round_end;
  logic [IDX_W:0]     nxt;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_PEC-1:0] m);
    lowest_set = '0;
    for (int i = NUM_PEC - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  // Returns {found, index} of the lowest set bit strictly above cur.
  function automatic logic [IDX_W:0] next_above(input logic [NUM_PEC-1:0] m,
                                                input logic [IDX_W-1:0] cur);
    next_above = '0;
    for (int i = NUM_PEC - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) next_above = {1'b1, IDX_W'(i)};
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    mask_d    = mask_q;
    nrnd_d    = nrnd_q;
    rnd_d     = rnd_q;
    cur_d     = cur_q;
    rdy_d     = rdy_q;
    err_d     = err_q | (|(pec_get_wei & ~rdy_q));
    round_end = 1'b0;
    nxt       = next_above(mask_q, cur_q);
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          mode_d = cfg_mode;
          mask_d = cfg_pec_mask;
          nrnd_d = (cfg_num_round == '0) ? RND_W'(1) : cfg_num_round;
          rnd_d  = '0;
          err_d  = 1'b0;
          rdy_d  = '0;
          if (cfg_pec_mask == '0) begin
            state_d = S_DONE;
            cur_d   = '0;
          end else begin
            state_d = S_FETCH;
            cur_d   = cfg_mode ? '0 : lowest_set(cfg_pec_mask);
          end
        end
      end
      S_FETCH: begin
        if (fetch_ack) begin
          state_d = S_OFFER;
          rdy_d   = mode_q ? mask_q : ({{(NUM_PEC-1){1'b0}}, 1'b1} << cur_q);
        end
      end
      S_OFFER: begin
        // In sequential mode only the cur_q bit is ever set, so this clears it on its get.
        rdy_d = rdy_q & ~pec_get_wei;
        if (rdy_d == '0) begin
          if (!mode_q && nxt[IDX_W]) begin
            cur_d   = nxt[IDX_W-1:0];
            state_d = S_FETCH;
          end else begin
            round_end = 1'b1;
            cur_d     = mode_q ? '0 : lowest_set(mask_q);
          end
        end
        if (round_end) begin
          rnd_d   = rnd_q + RND_W'(1);
          state_d = (rnd_d == nrnd_q) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cur_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      mask_q  <= '0;
      nrnd_q  <= '0;
      rnd_q   <= '0;
      cur_q   <= '0;
      rdy_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      nrnd_q  <= nrnd_d;
      rnd_q   <= rnd_d;
      cur_q   <= cur_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  assign fetch_req   = (state_q == S_FETCH);
  assign pec_rdy_wei = rdy_q;
  assign busy        = (state_q == S_FETCH) || (state_q == S_OFFER);
  assign done        = (state_q == S_DONE);
  assign cur_pec     = (busy && !mode_q) ? cur_q : '0;
  assign err_get     = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ctrl_wei_seq.sv
// Directed bench for ctrl_wei_seq: sequential, skip/wrap, broadcast, edge
// configurations, protocol errors and mid-operation reset.
module tb_ctrl_wei_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic        cfg_mode;
  logic [15:0] cfg_pec_mask;
  logic [7:0]  cfg_num_round;
  logic        fetch_req;
  logic        fetch_ack;
  logic [15:0] pec_rdy_wei;
  logic [15:0] pec_get_wei;
  logic [3:0]  cur_pec;
  logic        busy;
  logic        done;
  logic        err_get;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int n_ack = 0;

  ctrl_wei_seq #(.NUM_PEC(16), .RND_W(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_mode(cfg_mode),
    .cfg_pec_mask(cfg_pec_mask), .cfg_num_round(cfg_num_round),
    .fetch_req(fetch_req), .fetch_ack(fetch_ack),
    .pec_rdy_wei(pec_rdy_wei), .pec_get_wei(pec_get_wei),
    .cur_pec(cur_pec), .busy(busy), .done(done), .err_get(err_get),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start pulse, then scramble cfg_* to show they are only sampled at start.
  task automatic start(input logic mode, input logic [15:0] mask, input logic [7:0] rnd);
    cfg_mode = mode; cfg_pec_mask = mask; cfg_num_round = rnd; cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    cfg_mode = 1'($urandom_range(0, 1));
    cfg_pec_mask = 16'($urandom_range(0, 65535));
    cfg_num_round = 8'($urandom_range(0, 255));
  endtask

  // Ack two cycles after req, get three cycles after rdy.
  task automatic ack_fetch;
    tick;
    chk("req_hold", fetch_req, 1);
    tick;
    fetch_ack = 1'b1;
    tick;
    fetch_ack = 1'b0;
    n_ack++;
    chk("req_drop", fetch_req, 0);
  endtask

  task automatic serve(input int p, input logic last);
    chk("seq_req", fetch_req, 1);
    chk("seq_cur", cur_pec, p);
    chk("seq_busy", busy, 1);
    ack_fetch;
    chk("seq_rdy", pec_rdy_wei, 32'(16'h1 << p));
    tick; tick; tick;
    chk("seq_rdy_hold", pec_rdy_wei, 32'(16'h1 << p));
    pec_get_wei = 16'h1 << p;
    tick;
    pec_get_wei = '0;
    chk("seq_rdy_clr", pec_rdy_wei, 0);
    if (last) begin
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_req", fetch_req, 0);
      tick;
      chk("end_done_pulse", done, 0);
      chk("end_idle", dbg_state, 0);
    end
  endtask

  task automatic bcast_get(input logic [15:0] g, input logic [15:0] exp_rdy);
    pec_get_wei = g;
    tick;
    pec_get_wei = '0;
    chk("bc_rdy", pec_rdy_wei, 32'(exp_rdy));
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_mode = 1'b0; cfg_pec_mask = '0;
    cfg_num_round = '0; fetch_ack = 1'b0; pec_get_wei = '0;
    tick; tick;
    rst = 1'b0;
    chk("rst_req", fetch_req, 0);
    chk("rst_rdy", pec_rdy_wei, 0);
    chk("rst_cur", cur_pec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_get, 0);
    chk("rst_state", dbg_state, 0);
    tick;

    // Sequential over all 16 PECs, one round.
    n_ack = 0;
    start(1'b0, 16'hFFFF, 8'd1);
    for (int p = 0; p < 16; p++) serve(p, p == 15);
    chk("seq_acks", n_ack, 16);
    chk("seq_err", err_get, 0);

    // Skip and wrap: 0,5,10,15 three times.
    n_ack = 0;
    start(1'b0, 16'h8421, 8'd3);
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 4; k++) serve(k * 5, (r == 2) && (k == 3));
    chk("skip_acks", n_ack, 12);

    // Broadcast, two rounds over PECs 4..7.
    n_ack = 0;
    start(1'b1, 16'h00F0, 8'd2);
    for (int r = 0; r < 2; r++) begin
      chk("bc_req", fetch_req, 1);
      chk("bc_cur", cur_pec, 0);
      ack_fetch;
      chk("bc_rdy_all", pec_rdy_wei, 32'h00F0);
      bcast_get(16'h0030, 16'h00C0);
      bcast_get(16'h0040, 16'h0080);
      bcast_get(16'h0080, 16'h0000);
      if (r == 0) chk("bc_refetch", fetch_req, 1);
    end
    chk("bc_done", done, 1);
    chk("bc_busy", busy, 0);
    chk("bc_acks", n_ack, 2);
    tick;

    // Empty mask: done one cycle after start, no fetch.
    start(1'b0, 16'h0000, 8'd4);
    chk("zero_done", done, 1);
    chk("zero_req", fetch_req, 0);
    chk("zero_busy", busy, 0);
    tick;
    chk("zero_done_pulse", done, 0);

    // Zero rounds behaves as one round.
    n_ack = 0;
    start(1'b0, 16'h0001, 8'd0);
    serve(0, 1'b1);
    chk("rnd0_acks", n_ack, 1);

    // Protocol errors: stray get on PEC 3 while PEC 2 offered; start while busy.
    start(1'b0, 16'h000C, 8'd1);
    chk("err_cur", cur_pec, 2);
    ack_fetch;
    chk("err_rdy", pec_rdy_wei, 32'h0004);
    pec_get_wei = 16'h0008;
    cfg_start = 1'b1; cfg_mode = 1'b1; cfg_pec_mask = 16'hFFFF;
    tick;
    pec_get_wei = '0; cfg_start = 1'b0;
    chk("err_set", err_get, 1);
    chk("err_rdy_kept", pec_rdy_wei, 32'h0004);
    chk("err_cur_kept", cur_pec, 2);
    chk("err_busy", busy, 1);
    pec_get_wei = 16'h0004;
    tick;
    pec_get_wei = '0;
    chk("err_adv_rdy", pec_rdy_wei, 0);
    serve(3, 1'b1);
    chk("err_sticky", err_get, 1);
    start(1'b0, 16'h0001, 8'd1);
    chk("err_cleared", err_get, 0);
    serve(0, 1'b1);

    // Reset while offering to PEC 7, then restart from the lowest bit.
    start(1'b0, 16'h00FF, 8'd1);
    for (int p = 0; p < 7; p++) serve(p, 1'b0);
    chk("mid_cur", cur_pec, 7);
    ack_fetch;
    chk("mid_rdy", pec_rdy_wei, 32'h0080);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_req", fetch_req, 0);
    chk("mid_rdy0", pec_rdy_wei, 0);
    chk("mid_cur0", cur_pec, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    tick;
    chk("mid_no_done", done, 0);
    start(1'b0, 16'h00FF, 8'd1);
    for (int p = 0; p < 8; p++) serve(p, p == 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
